// File: rtl/idct_pkg.sv
// Shared constants, FSM states and index types for the 8x8 inverse DCT.
// The output clamp is enabled by defining IDCT_CLAMP_EN.
package idct_pkg;

    localparam int N      = 8;
    localparam int Q      = 10;
    localparam int ROUND  = 512;
    localparam int COEF_W = 12;

    typedef enum logic [1:0] {
        LOAD,
        ROW,
        COL,
        OUT
    } state_e;

    typedef logic [2:0] kn_t;
    typedef logic [5:0] addr_t;

endpackage

// File: rtl/idct_cos1d_lut.sv
// Q10 1D IDCT basis: c(k,n) = round(1024*a(k)*cos((2n+1)k*pi/16)).
// Uses cosine symmetry over a 9-entry magnitude table.
module idct_cos1d_lut
    import idct_pkg::*;
(
    input  logic [2:0]         k_i,
    input  logic [2:0]         n_i,
    output logic signed [11:0] c_o
);

    logic [6:0]         mk;
    logic [4:0]         m;
    logic [4:0]         f;
    logic [4:0]         idx;
    logic               neg;
    logic signed [11:0] mag;

    always_comb begin
        mk  = {3'b0, n_i, 1'b1} * {4'b0, k_i};
        m   = mk[4:0];
        // angle index mod 32, folded into 0..16 then 0..8 with sign
        f   = (m > 5'd16) ? (5'd0 - m) : m;
        neg = (f > 5'd8);
        idx = neg ? (5'd16 - f) : f;
        unique case (idx)
            5'd0:    mag = 12'sd512;
            5'd1:    mag = 12'sd502;
            5'd2:    mag = 12'sd473;
            5'd3:    mag = 12'sd426;
            5'd4:    mag = 12'sd362;
            5'd5:    mag = 12'sd284;
            5'd6:    mag = 12'sd196;
            5'd7:    mag = 12'sd100;
            default: mag = 12'sd0;
        endcase
        if (k_i == 3'd0) begin
            c_o = 12'sd362;
        end else begin
            c_o = neg ? -mag : mag;
        end
    end

endmodule

// File: rtl/idct_8x8.sv
// Sequential 8x8 IDCT: load 64 coefficients, row pass, column pass, stream out.
// Define IDCT_CLAMP_EN to level-shift and clamp outputs to 0..255.
module idct_8x8
    import idct_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    state_e state_q, state_d;
    addr_t  idx_q, idx_d;
    kn_t    mac_q, mac_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic              in_ready_q;
    logic              busy_q;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0] cbuf [64];
    logic [DATA_W-1:0] tbuf [64];

    kn_t                     lut_n;
    logic signed [11:0]      coef;
    logic [DATA_W-1:0]       opnd;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] opnd_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic                    last_mac;
    logic                    accept;
    logic                    take;
    addr_t                   idx_inc;

    function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] x);
`ifdef IDCT_CLAMP_EN
        logic signed [DATA_W:0] v;
        v = $signed({x[DATA_W-1], x}) + (DATA_W+1)'(128);
        if (v < 0) begin
            return '0;
        end else if (v > (DATA_W+1)'(255)) begin
            return DATA_W'(255);
        end else begin
            return v[DATA_W-1:0];
        end
`else
        return x;
`endif
    endfunction

    // ROW indexes (k1,n2) with k2=mac; COL indexes (n1,n2) with k1=mac
    assign lut_n = (state_q == ROW) ? idx_q[2:0] : idx_q[5:3];

    idct_cos1d_lut u_lut (
        .k_i (mac_q),
        .n_i (lut_n),
        .c_o (coef)
    );

    always_comb begin
        opnd = (state_q == ROW) ? cbuf[{idx_q[5:3], mac_q}]
                                : tbuf[{mac_q, idx_q[2:0]}];
        coef_ext = {{(ACC_W-12){coef[11]}}, coef};
        opnd_ext = {{(ACC_W-DATA_W){opnd[DATA_W-1]}}, opnd};
        prod     = coef_ext * opnd_ext;
        sum      = ((mac_q == 3'd0) ? '0 : acc_q) + prod;
        rnd      = (sum + ACC_W'(ROUND)) >>> Q;
    end

    assign last_mac = (mac_q == 3'd7);
    assign accept   = in_valid & in_ready_q;
    assign take     = out_valid_q & out_ready;
    assign idx_inc  = idx_q + 6'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mac_d       = mac_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    idx_d = idx_inc;
                    if (idx_q == 6'd63) state_d = ROW;
                end
            end
            ROW, COL: begin
                mac_d = mac_q + 3'd1;
                acc_d = sum;
                if (last_mac) begin
                    idx_d = idx_inc;
                    if (idx_q == 6'd63) begin
                        if (state_q == ROW) begin
                            state_d = COL;
                        end else begin
                            state_d     = OUT;
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b0;
                            out_data_d  = fmt(cbuf[0]);
                        end
                    end
                end
            end
            OUT: begin
                if (take) begin
                    if (out_last_q) begin
                        state_d     = LOAD;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = fmt(cbuf[idx_inc]);
                        out_last_d = (idx_inc == 6'd63);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            mac_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mac_q       <= mac_d;
            acc_q       <= acc_d;
            in_ready_q  <= (state_d == LOAD);
            busy_q      <= (state_d != LOAD);
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Buffer contents need no reset; a partial block is simply discarded
    always_ff @(posedge clk) begin
        if (state_q == LOAD && accept) begin
            cbuf[idx_q] <= in_data;
        end
        if (state_q == ROW && last_mac) begin
            tbuf[idx_q] <= rnd[DATA_W-1:0];
        end
        if (state_q == COL && last_mac) begin
            cbuf[idx_q] <= rnd[DATA_W-1:0];
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_idct_8x8.sv
// Directed bench for idct_8x8: DC, AC, zero, backpressure, input gaps, resets.
// Expected values follow IDCT_CLAMP_EN when it is defined.
module tb_idct_8x8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    idct_8x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IDCT_CLAMP_EN
    localparam logic [31:0] E_DC   = 32'd228;
    localparam logic [31:0] E_NEG  = 32'd0;
    localparam logic [31:0] E_ZERO = 32'd128;
    localparam logic [255:0] E_AC  = {32'd0, 32'd0, 32'd28, 32'd93,
                                      32'd163, 32'd228, 32'd255, 32'd255};
`else
    localparam logic [31:0] E_DC   = 32'd100;
    localparam logic [31:0] E_NEG  = -32'sd200;
    localparam logic [31:0] E_ZERO = 32'd0;
    localparam logic [255:0] E_AC  = {-32'sd177, -32'sd151, -32'sd100, -32'sd35,
                                      32'sd35, 32'sd100, 32'sd151, 32'sd177};
`endif

    // Returns just after the posedge that accepted coefficient 63
    task automatic send_block(input string nm, input logic [5:0] pos,
                              input logic [31:0] val, input bit gaps);
        int  i = 0;
        int  g = 0;
        bit  acc;
        while (i < 64 && g < 1000) begin
            @(negedge clk);
            in_valid = gaps ? (g % 2 == 0) : 1'b1;
            in_data  = (i == int'(pos)) ? val : 32'd0;
            acc = in_valid && in_ready;
            @(posedge clk);
            g++;
            if (acc) i++;
        end
        #1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        n_cmp++;
        if (i != 64) begin
            n_err++;
            $display("FAIL %s load: accepted %0d, required 64", nm, i);
        end
    endtask

    task automatic run_block(input string nm, input logic [5:0] pos,
                             input logic [31:0] val, input bit gaps,
                             input bit stall, input bit by_row,
                             input logic [255:0] ev);
        int lat = 0;
        int n = 0;
        int g = 0;
        int ix;
        bit seen = 0;
        logic [31:0] exp;
        logic [31:0] hold;
        out_ready = 1'b1;
        send_block(nm, pos, val, gaps);
        while (!seen && lat < 1200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1;
            if (lat == 512) begin
                n_cmp++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s mid busy/in_ready: %b/%b, required 1/0",
                             nm, busy, in_ready);
                end
            end
        end
        // out_valid must appear in the cycle starting 1024 edges after the accept edge
        n_cmp++;
        if (lat != 1024) begin
            n_err++;
            $display("FAIL %s latency: %0d edges, required 1024", nm, lat);
        end
        while (n < 64 && g < 400) begin
            if (stall && n == 10) begin
                hold = out_data;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    n_cmp++;
                    if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s stall hold: data %0h valid %b in_ready %b, required %0h 1 0",
                                 nm, out_data, out_valid, in_ready, hold);
                    end
                end
                out_ready = 1'b1;
            end
            if (out_valid) begin
                ix  = by_row ? (n / 8) : (n % 8);
                exp = ev[ix*32 +: 32];
                n_cmp++;
                if (out_data !== exp) begin
                    n_err++;
                    $display("FAIL %s sample %0d: got %0d, required %0d",
                             nm, n, $signed(out_data), $signed(exp));
                end
                n_cmp++;
                if (out_last !== (n == 63)) begin
                    n_err++;
                    $display("FAIL %s last at %0d: got %b, required %b",
                             nm, n, out_last, (n == 63));
                end
                n++;
            end
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (n != 64 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s end: samples %0d valid %b in_ready %b, required 64 0 1",
                     nm, n, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0 || out_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset state: rdy %b vld %b last %b busy %b data %0h, required all 0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset release in_ready: %b, required 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL first edge in_ready/busy: %b/%b, required 1/0", in_ready, busy);
        end
    endtask

    task automatic test_dc();
        run_block("dc800", 6'd0, 32'd800, 1'b0, 1'b0, 1'b0, {8{E_DC}});
    endtask

    task automatic test_neg_dc();
        run_block("dcneg", 6'd0, -32'sd1600, 1'b0, 1'b0, 1'b0, {8{E_NEG}});
    endtask

    task automatic test_zero();
        run_block("zero", 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, {8{E_ZERO}});
    endtask

    task automatic test_ac();
        run_block("ac_v", 6'd8, 32'd1024, 1'b0, 1'b0, 1'b1, E_AC);
        run_block("ac_h", 6'd1, 32'd1024, 1'b0, 1'b0, 1'b0, E_AC);
    endtask

    task automatic test_backpressure();
        run_block("bp", 6'd0, 32'd800, 1'b0, 1'b1, 1'b0, {8{E_DC}});
    endtask

    task automatic test_input_gaps();
        run_block("gaps", 6'd0, 32'd800, 1'b1, 1'b0, 1'b0, {8{E_DC}});
    endtask

    task automatic test_reset_mid();
        send_block("rstmid", 6'd0, 32'd1600, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0 || out_data !== 32'd0) begin
            n_err++;
            $display("FAIL mid reset outputs: rdy %b vld %b last %b busy %b data %0h, required all 0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_block("after_rst", 6'd0, 32'd800, 1'b0, 1'b0, 1'b0, {8{E_DC}});
    endtask

    initial begin
        test_reset();
        test_dc();
        test_neg_dc();
        test_zero();
        test_ac();
        test_backpressure();
        test_input_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
